// File: rtl/uart_stream_arb.sv
// uart_stream_arb: two-requester round-robin arbiter feeding one UART
// write stream. The owner keeps the stream until it sends TLAST or hits
// MAX_BURST beats. After every grant there is one IDLE cycle before the
// next arbitration.
//
// Optional build macro UART_STREAM_ARB_OUTREG_EN adds a one-entry output
// register between the mux and the M_* ports. This costs one cycle of
// latency and still carries one beat per cycle. Without the macro, the
// M_* path is combinational.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | no owner; arbitrate valid requesters (tie -> not LAST_SRV)
// GRANT0 | S0 owns the stream until TLAST or MAX_BURST beats
// GRANT1 | S1 owns the stream until TLAST or MAX_BURST beats
module uart_stream_arb #(
    parameter int MAX_BURST = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] S0_TDATA,
    input  logic       S0_TVALID,
    input  logic       S0_TLAST,
    output logic       S0_TREADY,
    input  logic [7:0] S1_TDATA,
    input  logic       S1_TVALID,
    input  logic       S1_TLAST,
    output logic       S1_TREADY,
    output logic [7:0] M_TDATA,
    output logic       M_TVALID,
    output logic       M_TLAST,
    input  logic       M_TREADY,
    output logic [1:0] GRANT
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_GRANT0 = 2'd1,
        ST_GRANT1 = 2'd2
    } state_t;

    localparam logic [8:0] LP_MAX_BURST = 9'(MAX_BURST);

    state_t     r_state;
    state_t     w_state_nxt;
    logic       r_last_srv;
    logic [7:0] r_bcnt;

    logic [8:0] w_bcnt_inc;
    logic       w_s0_sel;
    logic       w_s1_sel;
    logic [7:0] w_up_data;
    logic       w_up_valid;
    logic       w_up_last;
    logic       w_up_ready;
    logic       w_accept;
    logic       w_end;

    assign w_s0_sel   = (r_state == ST_GRANT0);
    assign w_s1_sel   = (r_state == ST_GRANT1);
    assign GRANT      = {w_s1_sel, w_s0_sel};
    assign S0_TREADY  = w_s0_sel & w_up_ready;
    assign S1_TREADY  = w_s1_sel & w_up_ready;

    // Select the owner's stream; IDLE presents an all-zero, invalid beat
    always_comb begin
        w_up_data  = 8'h00;
        w_up_valid = 1'b0;
        w_up_last  = 1'b0;
        case (r_state)
            ST_GRANT0: begin
                w_up_data  = S0_TDATA;
                w_up_valid = S0_TVALID;
                w_up_last  = S0_TLAST;
            end
            ST_GRANT1: begin
                w_up_data  = S1_TDATA;
                w_up_valid = S1_TVALID;
                w_up_last  = S1_TLAST;
            end
            default: begin
                w_up_data  = 8'h00;
                w_up_valid = 1'b0;
                w_up_last  = 1'b0;
            end
        endcase
    end

    // Beats are counted at the requester side, so the output register
    // (when built in) does not change burst boundaries.
    assign w_accept   = w_up_valid & w_up_ready;
    assign w_bcnt_inc = {1'b0, r_bcnt} + 9'd1;
    assign w_end      = w_accept & (w_up_last | (w_bcnt_inc == LP_MAX_BURST));

    // Next-state: round-robin arbitration in IDLE, release on end of grant
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (S0_TVALID && S1_TVALID)
                    w_state_nxt = r_last_srv ? ST_GRANT0 : ST_GRANT1;
                else if (S0_TVALID)
                    w_state_nxt = ST_GRANT0;
                else if (S1_TVALID)
                    w_state_nxt = ST_GRANT1;
            end
            ST_GRANT0, ST_GRANT1: begin
                if (w_end)
                    w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_nxt;
    end

    // Burst counter and last-served flag; LAST_SRV resets to 1 so S0 wins the first tie
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bcnt     <= 8'd0;
            r_last_srv <= 1'b1;
        end else if (w_end) begin
            r_bcnt     <= 8'd0;
            r_last_srv <= w_s1_sel;
        end else if (w_accept) begin
            r_bcnt     <= w_bcnt_inc[7:0];
        end
    end

`ifdef UART_STREAM_ARB_OUTREG_EN
    logic       r_ob_valid;
    logic       r_ob_last;
    logic [7:0] r_ob_data;

    assign w_up_ready = ~r_ob_valid | M_TREADY;

    // One-entry output register; refills whenever it is empty or draining
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ob_valid <= 1'b0;
            r_ob_last  <= 1'b0;
            r_ob_data  <= 8'h00;
        end else if (w_up_ready) begin
            r_ob_valid <= w_up_valid;
            r_ob_last  <= w_up_last;
            r_ob_data  <= w_up_data;
        end
    end

    assign M_TVALID = r_ob_valid;
    assign M_TLAST  = r_ob_last;
    assign M_TDATA  = r_ob_data;
`else
    assign w_up_ready = M_TREADY;
    assign M_TVALID   = w_up_valid;
    assign M_TLAST    = w_up_last;
    assign M_TDATA    = w_up_data;
`endif

endmodule

// File: tb/tb_uart_stream_arb.sv
// Testbench for uart_stream_arb (MAX_BURST=4). Expected output beats are
// queued in arbitration order when stimulus is queued, and they are popped
// and compared when the DUT emits a beat.
module tb_uart_stream_arb;

`ifdef UART_STREAM_ARB_OUTREG_EN
    localparam int OREG = 1;
`else
    localparam int OREG = 0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] S0_TDATA, S1_TDATA, M_TDATA;
    logic       S0_TVALID, S0_TLAST, S0_TREADY;
    logic       S1_TVALID, S1_TLAST, S1_TREADY;
    logic       M_TVALID, M_TLAST, M_TREADY;
    logic [1:0] GRANT;

    int         n_tests = 0;
    int         n_fail  = 0;
    int         cyc     = 0;
    int         n_out   = 0;
    logic       mrdy_toggle = 1'b0;

    logic [8:0] q0[$];
    logic [8:0] q1[$];
    logic [8:0] exp_q[$];
    int         out_cyc_q[$];

    uart_stream_arb #(.MAX_BURST(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .S0_TDATA  (S0_TDATA),
        .S0_TVALID (S0_TVALID),
        .S0_TLAST  (S0_TLAST),
        .S0_TREADY (S0_TREADY),
        .S1_TDATA  (S1_TDATA),
        .S1_TVALID (S1_TVALID),
        .S1_TLAST  (S1_TLAST),
        .S1_TREADY (S1_TREADY),
        .M_TDATA   (M_TDATA),
        .M_TVALID  (M_TVALID),
        .M_TLAST   (M_TLAST),
        .M_TREADY  (M_TREADY),
        .GRANT     (GRANT)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // S0 source: hold the head of q0 until it is accepted
    initial begin
        S0_TVALID = 1'b0; S0_TLAST = 1'b0; S0_TDATA = 8'h00;
        forever begin
            @(negedge clk);
            if (S0_TVALID && S0_TREADY && q0.size() > 0) void'(q0.pop_front());
            @(posedge clk);
            #1;
            if (q0.size() > 0) begin
                S0_TVALID = 1'b1;
                {S0_TLAST, S0_TDATA} = q0[0];
            end else begin
                S0_TVALID = 1'b0; S0_TLAST = 1'b0; S0_TDATA = 8'h00;
            end
        end
    end

    // S1 source
    initial begin
        S1_TVALID = 1'b0; S1_TLAST = 1'b0; S1_TDATA = 8'h00;
        forever begin
            @(negedge clk);
            if (S1_TVALID && S1_TREADY && q1.size() > 0) void'(q1.pop_front());
            @(posedge clk);
            #1;
            if (q1.size() > 0) begin
                S1_TVALID = 1'b1;
                {S1_TLAST, S1_TDATA} = q1[0];
            end else begin
                S1_TVALID = 1'b0; S1_TLAST = 1'b0; S1_TDATA = 8'h00;
            end
        end
    end

    // UART ready: steady high, or toggling every cycle
    initial begin
        M_TREADY = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            M_TREADY = mrdy_toggle ? ~M_TREADY : 1'b1;
        end
    end

    // Output monitor and handshake rules
    initial begin
        logic       stall_pend;
        logic [7:0] stall_data;
        logic [8:0] e;
        stall_pend = 1'b0;
        stall_data = 8'h00;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (stall_pend && M_TVALID) check("stall_hold", M_TDATA, stall_data);
                if (M_TVALID && M_TREADY) begin
                    if (exp_q.size() == 0) begin
                        check("spurious_beat", M_TVALID, 1'b0);
                    end else begin
                        e = exp_q.pop_front();
                        check("beat", {M_TLAST, M_TDATA}, e);
                        out_cyc_q.push_back(cyc);
                        n_out++;
                    end
                end
                stall_pend = M_TVALID && !M_TREADY;
                stall_data = M_TDATA;
                if (S0_TVALID && GRANT != 2'b01) check("s0_nonowner_rdy", S0_TREADY, 1'b0);
                if (S1_TVALID && GRANT != 2'b10) check("s1_nonowner_rdy", S1_TREADY, 1'b0);
`ifdef UART_STREAM_ARB_OUTREG_EN
                if (GRANT == 2'b01) check("s0_rdy", S0_TREADY, !M_TVALID || M_TREADY);
`else
                if (GRANT == 2'b01) check("s0_rdy_mirror", S0_TREADY, M_TREADY);
`endif
            end else begin
                stall_pend = 1'b0;
            end
        end
    end

    task automatic check_outputs_zero(input string tag);
        check({tag, "_m_tvalid"}, M_TVALID, 1'b0);
        check({tag, "_m_tdata"}, M_TDATA, 8'h00);
        check({tag, "_grant"}, GRANT, 2'b00);
        check({tag, "_s0_tready"}, S0_TREADY, 1'b0);
        check({tag, "_s1_tready"}, S1_TREADY, 1'b0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        q0.delete(); q1.delete(); exp_q.delete();
        #1;
        check_outputs_zero("reset");
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic wait_drain(input int budget, input string tag);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_drain"}, exp_q.size(), 0);
    endtask

    task automatic run_basic();
        int t0;
        out_cyc_q.delete();
        q0.push_back({1'b0, 8'h41}); q0.push_back({1'b0, 8'h42}); q0.push_back({1'b1, 8'h43});
        exp_q.push_back({1'b0, 8'h41}); exp_q.push_back({1'b0, 8'h42}); exp_q.push_back({1'b1, 8'h43});
        t0 = cyc;
        @(negedge clk); check("basic_grant_wait", GRANT, 2'b00);
        @(negedge clk); check("basic_grant0", GRANT, 2'b01);
        repeat (3) @(negedge clk);
        check("basic_idle_after", GRANT, 2'b00);
        wait_drain(20, "basic");
        check("basic_nbeats", out_cyc_q.size(), 3);
        for (int i = 0; i < 3; i++) check("basic_beat_cycle", out_cyc_q[i], t0 + 2 + OREG + i);
    endtask

    task automatic run_tie();
        int t0;
        int offs[4];
        offs = '{2, 3, 5, 6};
        out_cyc_q.delete();
        q0.push_back({1'b0, 8'hA0}); q0.push_back({1'b1, 8'hA1});
        q1.push_back({1'b0, 8'hB0}); q1.push_back({1'b1, 8'hB1});
        exp_q.push_back({1'b0, 8'hA0}); exp_q.push_back({1'b1, 8'hA1});
        exp_q.push_back({1'b0, 8'hB0}); exp_q.push_back({1'b1, 8'hB1});
        t0 = cyc;
        repeat (2) @(negedge clk); check("tie_first_s0", GRANT, 2'b01);
        repeat (2) @(negedge clk); check("tie_gap_idle", GRANT, 2'b00);
        @(negedge clk);            check("tie_then_s1", GRANT, 2'b10);
        wait_drain(30, "tie");
        for (int i = 0; i < 4; i++) check("tie_beat_cycle", out_cyc_q[i], t0 + offs[i] + OREG);
        repeat (2) @(negedge clk);
        q0.push_back({1'b0, 8'hC0}); q0.push_back({1'b1, 8'hC1});
        q1.push_back({1'b0, 8'hD0}); q1.push_back({1'b1, 8'hD1});
        exp_q.push_back({1'b0, 8'hC0}); exp_q.push_back({1'b1, 8'hC1});
        exp_q.push_back({1'b0, 8'hD0}); exp_q.push_back({1'b1, 8'hD1});
        repeat (2) @(negedge clk); check("tie2_s0_again", GRANT, 2'b01);
        wait_drain(30, "tie2");
    endtask

    task automatic run_burst();
        for (int i = 0; i < 10; i++) q1.push_back({1'b0, 8'(8'h50 + i)});
        for (int i = 0; i < 4; i++) exp_q.push_back({1'b0, 8'(8'h50 + i)});
        exp_q.push_back({1'b0, 8'h30}); exp_q.push_back({1'b1, 8'h31});
        for (int i = 4; i < 10; i++) exp_q.push_back({1'b0, 8'(8'h50 + i)});
        @(negedge clk);
        q0.push_back({1'b0, 8'h30}); q0.push_back({1'b1, 8'h31});
        wait_drain(80, "burst");
        repeat (3) @(negedge clk);
        check("burst_hold_grant", GRANT, 2'b10);
    endtask

    task automatic run_stall();
        mrdy_toggle = 1'b1;
        q0.push_back({1'b0, 8'h10}); q0.push_back({1'b0, 8'h11});
        q0.push_back({1'b0, 8'h12}); q0.push_back({1'b1, 8'h13});
        exp_q.push_back({1'b0, 8'h10}); exp_q.push_back({1'b0, 8'h11});
        exp_q.push_back({1'b0, 8'h12}); exp_q.push_back({1'b1, 8'h13});
        wait_drain(40, "stall");
        mrdy_toggle = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic run_reset_mid();
        int base;
        int n;
        for (int i = 0; i < 5; i++) begin
            q0.push_back({(i == 4), 8'(8'h60 + i)});
            exp_q.push_back({(i == 4), 8'(8'h60 + i)});
        end
        base = n_out;
        n = 0;
        while (n_out < base + 2 && n < 30) begin
            @(posedge clk);
            #2;
            n++;
        end
        check("rstmid_two_beats", n_out - base, 2);
        rst_n = 1'b0;
        #1;
        check_outputs_zero("rstmid");
        q0.delete(); exp_q.delete();
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        @(negedge clk);
        q1.push_back({1'b0, 8'h70}); q1.push_back({1'b1, 8'h71});
        exp_q.push_back({1'b0, 8'h70}); exp_q.push_back({1'b1, 8'h71});
        repeat (2) @(negedge clk); check("rstmid_s1_grant", GRANT, 2'b10);
        wait_drain(20, "rstmid");
        repeat (3) @(negedge clk);
        check("rstmid_idle", GRANT, 2'b00);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        rst_n = 1'b1;
        #2;
        do_reset(); run_basic();
        do_reset(); run_tie();
        do_reset(); run_burst();
        do_reset(); run_stall();
        do_reset(); run_reset_mid();
        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
